fastinput_poller: RTL and testbench

- Host-side initiator for the fast-input counter link; the opposite end of the fast-input responder.
- Issues the one-byte poll request (0x05) through the byte-level UART transmitter and collects the 19-byte reply from the byte-level UART receiver.
- Checks the ACK header and the 16-bit checksum, then presents the four 32-bit channel counts with a valid strobe.
- Sits between the UART byte transmitter/receiver pair and host logic.

---
 rtl/fastinput_poller_if.sv | 37 +++
 rtl/fastinput_poller.sv | 145 ++++++++++++++
 tb/tb_fastinput_poller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fastinput_poller_if.sv
// Bundle of the poller's host, UART-transmitter and UART-receiver signals.
//
// All control signals here are single-cycle pulses sampled on posedge clk;
// there is no back-pressure. tx_start asks the transmitter to send tx_data,
// which stays stable until tx_done. rx_done qualifies rx_data for exactly
// one cycle. frame_valid, frame_err and timeout are mutually exclusive and
// coincide with the cycle busy falls.
interface fastinput_poller_if;
  logic        poll_req;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] channel0;
  logic [31:0] channel1;
  logic [31:0] channel2;
  logic [31:0] channel3;
  logic        frame_valid;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  // Environment side: host logic plus the UART byte transmitter/receiver.
  modport master (
    output poll_req, tx_done, rx_data, rx_done,
    input  tx_start, tx_data, channel0, channel1, channel2, channel3,
           frame_valid, frame_err, timeout, busy
  );

  // Poller side.
  modport slave (
    input  poll_req, tx_done, rx_data, rx_done,
    output tx_start, tx_data, channel0, channel1, channel2, channel3,
           frame_valid, frame_err, timeout, busy
  );
endinterface

// File: rtl/fastinput_poller.sv
// Host-side initiator of the fast-input counter link. Sends the one-byte
// poll request, collects the 19-byte reply (ACK, four little-endian 32-bit
// counts, 16-bit checksum), validates it and publishes the counts.
module fastinput_poller #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [7:0]  REQ_BYTE       = 8'h05,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic               clk,
  input  logic               rst,
  fastinput_poller_if.slave  bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_TX = 3'd2,
    RECV    = 3'd3,
    CHECK   = 3'd4
  } state_t;

  state_t      state;
  logic [4:0]  byte_cnt;
  logic [31:0] to_cnt;
  // Reply bytes 1..18 live at index 0..17; byte 0 is only compared.
  logic [7:0]  shd [18];

  logic [4:0]  wr_idx;
  logic [31:0] sh_ch0, sh_ch1, sh_ch2, sh_ch3;
  logic [31:0] sum;
  logic [15:0] cks;
  logic        strobe_now;

  assign dbg_state = state;
  assign wr_idx    = byte_cnt - 5'd1;

  assign sh_ch0 = {shd[3],  shd[2],  shd[1],  shd[0]};
  assign sh_ch1 = {shd[7],  shd[6],  shd[5],  shd[4]};
  assign sh_ch2 = {shd[11], shd[10], shd[9],  shd[8]};
  assign sh_ch3 = {shd[15], shd[14], shd[13], shd[12]};
  assign sum    = sh_ch0 + sh_ch1 + sh_ch2 + sh_ch3;
  assign cks    = {shd[17], shd[16]};

  // A poll request arriving while a termination strobe is showing belongs
  // to the cycle busy falls, so it is dropped rather than accepted.
  assign strobe_now = bus.frame_valid | bus.frame_err | bus.timeout;

  // Poll sequencer: request, transmit handshake, reply capture and check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      to_cnt          <= '0;
      for (int i = 0; i < 18; i++) shd[i] <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.channel0    <= '0;
      bus.channel1    <= '0;
      bus.channel2    <= '0;
      bus.channel3    <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.tx_start    <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.timeout     <= 1'b0;
      case (state)
        IDLE: begin
          // Stray rx_done here is simply not looked at.
          if (bus.poll_req && !strobe_now) begin
            bus.tx_data  <= REQ_BYTE;
            bus.tx_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          // tx_start is high during this cycle; tx_done cannot be earlier.
          if (bus.tx_done) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
            state    <= RECV;
          end else begin
            state <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // Untimed: the transmitter is trusted to finish.
          if (bus.tx_done) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (bus.rx_done) begin
            to_cnt <= '0;
            if (byte_cnt == 5'd0) begin
              if (bus.rx_data != ACK_BYTE) begin
                bus.frame_err <= 1'b1;
                bus.busy      <= 1'b0;
                state         <= IDLE;
              end else begin
                byte_cnt <= 5'd1;
              end
            end else begin
              shd[wr_idx] <= bus.rx_data;
              byte_cnt    <= byte_cnt + 5'd1;
              if (byte_cnt == 5'd18) state <= CHECK;
            end
          end else if (to_cnt >= TIMEOUT_CYCLES - 32'd1) begin
            to_cnt      <= TIMEOUT_CYCLES;
            bus.timeout <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        CHECK: begin
          if (sum[15:0] == cks) begin
            bus.channel0    <= sh_ch0;
            bus.channel1    <= sh_ch1;
            bus.channel2    <= sh_ch2;
            bus.channel3    <= sh_ch3;
            bus.frame_valid <= 1'b1;
          end else begin
            bus.frame_err <= 1'b1;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fastinput_poller.sv
// Directed bench for fastinput_poller with a 100-cycle reply timeout.
module tb_fastinput_poller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  fastinput_poller_if bus();

  fastinput_poller #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_tx = 0, n_fv = 0, n_fe = 0, n_to = 0;
  int snap_tx, snap_fv, snap_str;
  logic [7:0] fr [19];

  // Pulse counters and strobe exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start)    n_tx++;
      if (bus.frame_valid) n_fv++;
      if (bus.frame_err)   n_fe++;
      if (bus.timeout)     n_to++;
      if (bus.frame_valid | bus.frame_err | bus.timeout) begin
        n_tests++;
        assert ($countones({bus.frame_valid, bus.frame_err, bus.timeout}) == 1)
        else begin
          n_fail++;
          $error("FAIL strobe_excl: got fv/fe/to=%b%b%b required one-hot",
                 bus.frame_valid, bus.frame_err, bus.timeout);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic set_frame(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3,
                           input logic [15:0] ck);
    logic [31:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    fr[0] = 8'h06;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        fr[1 + 4*k + j] = c[k][8*j +: 8];
    fr[17] = ck[7:0];
    fr[18] = ck[15:8];
  endtask

  // Bytes first..last with one idle cycle between them, none after the last.
  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      pulse_byte(fr[i]);
      if (i != last) tick();
    end
  endtask

  task automatic poll_start(input bit stray);
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
    chk("tx_start_hi", bus.tx_start, 1);
    chk("tx_data_req", bus.tx_data, 32'h05);
    chk("busy_hi", bus.busy, 1);
    tick();
    chk("tx_start_lo", bus.tx_start, 0);
    for (int i = 0; i < 10; i++) begin
      if (stray && i == 3) pulse_byte(8'h06);
      else tick();
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  // Called right after the final reply byte; frame_valid is two cycles on.
  task automatic expect_good(input string tag, input logic [31:0] c0, input logic [31:0] c3);
    chk({tag, "_fv_early"}, bus.frame_valid, 0);
    tick();
    chk({tag, "_fv"}, bus.frame_valid, 1);
    chk({tag, "_busy_lo"}, bus.busy, 0);
    chk({tag, "_ch0"}, bus.channel0, c0);
    chk({tag, "_ch3"}, bus.channel3, c3);
  endtask

  initial begin
    bus.poll_req = 1'b0;
    bus.tx_done  = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_done  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_ch0", bus.channel0, 0);
    chk("rst_ch3", bus.channel3, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Good frame; poll_req in the cycle busy falls is dropped
    poll_start(0);
    set_frame(32'h12345678, 32'h1, 32'h2, 32'hFFFFFFFF, 16'h567A);
    send_range(0, 18);
    expect_good("good", 32'h12345678, 32'hFFFFFFFF);
    chk("good_ch1", bus.channel1, 32'h1);
    chk("good_ch2", bus.channel2, 32'h2);
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
    chk("fv_one_cycle", bus.frame_valid, 0);
    chk("late_req_busy", bus.busy, 0);
    chk("late_req_tx_start", bus.tx_start, 0);
    chk("good_tx_count", n_tx, 1);
    tick();

    // Checksum off by one: frame_err, previous counts retained
    poll_start(0);
    set_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFD);
    send_range(0, 18);
    tick();
    chk("badck_fe", bus.frame_err, 1);
    chk("badck_fv", bus.frame_valid, 0);
    chk("badck_busy", bus.busy, 0);
    chk("badck_ch0", bus.channel0, 32'h12345678);
    tick();

    // Checksum wrap: 4 x 0xFFFFFFFF = 0xFFFFFFFC mod 2^32
    poll_start(0);
    set_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFC);
    send_range(0, 18);
    expect_good("wrap", 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();

    // Bad header, rest of reply arrives into IDLE
    snap_fv = n_fv;
    poll_start(0);
    set_frame(32'h11111111, 32'h0, 32'h0, 32'h0, 16'h1111);
    pulse_byte(8'h15);
    chk("hdr_fe", bus.frame_err, 1);
    chk("hdr_busy", bus.busy, 0);
    chk("hdr_state", dbg_state, 0);
    tick();
    chk("hdr_fe_one_cycle", bus.frame_err, 0);
    send_range(1, 18);
    repeat (3) tick();
    chk("hdr_no_fv", n_fv - snap_fv, 0);
    chk("hdr_ch0", bus.channel0, 32'hFFFFFFFF);

    // Timeout 100 cycles after the 7th byte
    poll_start(0);
    set_frame(32'h12345678, 32'h1, 32'h2, 32'hFFFFFFFF, 16'h567A);
    send_range(0, 6);
    repeat (99) tick();
    chk("to_early", bus.timeout, 0);
    chk("to_busy_hold", bus.busy, 1);
    tick();
    chk("to_pulse", bus.timeout, 1);
    chk("to_busy_lo", bus.busy, 0);
    chk("to_ch0", bus.channel0, 32'hFFFFFFFF);
    tick();
    chk("to_one_cycle", bus.timeout, 0);
    poll_start(0);
    send_range(0, 18);
    expect_good("after_to", 32'h12345678, 32'hFFFFFFFF);
    tick();

    // Stray bytes in IDLE and WAIT_TX, extra poll_req during RECV
    snap_tx = n_tx;
    pulse_byte(8'h06);
    tick();
    pulse_byte(8'hAA);
    tick();
    chk("stray_idle_busy", bus.busy, 0);
    poll_start(1);
    set_frame(32'hA5A5A5A5, 32'h01020304, 32'h0, 32'h10, 16'hA8B9);
    send_range(0, 4);
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
    send_range(5, 18);
    expect_good("stray", 32'hA5A5A5A5, 32'h00000010);
    chk("stray_ch1", bus.channel1, 32'h01020304);
    chk("stray_tx_count", n_tx - snap_tx, 1);
    tick();

    // Reset after 10 reply bytes
    snap_str = n_fv + n_fe + n_to;
    poll_start(0);
    set_frame(32'h12345678, 32'h1, 32'h2, 32'hFFFFFFFF, 16'h567A);
    send_range(0, 9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ch0", bus.channel0, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    chk("mid_rst_state", dbg_state, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("mid_rst_no_strobe", n_fv + n_fe + n_to - snap_str, 0);
    poll_start(0);
    send_range(0, 18);
    expect_good("post_rst", 32'h12345678, 32'hFFFFFFFF);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
